// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the UART memory loader: default framing bytes,
// payload command encoding, parser/executor state encodings and helpers
// that slice the 32-bit payload {b0,b1,b2,b3} into its fields.
// ---------------------------------------------------------------------------
package loader_pkg;

  localparam logic [7:0] DEF_START_BYTE = 8'h55;
  localparam logic [7:0] DEF_STOP_BYTE  = 8'hAA;
  localparam logic [7:0] DEF_ESC_BYTE   = 8'h7D;
  localparam logic [7:0] DEF_ACK_BYTE   = 8'h06;
  localparam logic [7:0] DEF_NAK_BYTE   = 8'h15;
  localparam logic [7:0] ESC_XOR        = 8'h20;

  // Payload byte count: 4 is a complete payload, 5 marks "too long".
  localparam logic [2:0] CNT_FULL = 3'd4;
  localparam logic [2:0] CNT_MAX  = 3'd5;

  typedef enum logic [1:0] {
    WRITE = 2'b00,
    LOAD  = 2'b01,
    RUN   = 2'b10,
    RSVD  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_BODY = 2'd1,
    P_ESC  = 2'd2
  } parser_state_e;

  typedef enum logic [2:0] {
    X_IDLE = 3'd0,
    X_ADDR = 3'd1,
    X_DLO  = 3'd2,
    X_DHI  = 3'd3,
    X_RESP = 3'd4
  } exec_state_e;

  // cmd = b0[7:6]
  function automatic cmd_e payload_cmd(input logic [31:0] p);
    return cmd_e'(p[31:30]);
  endfunction

  // addr = {b0[1:0], b1}
  function automatic logic [9:0] payload_addr(input logic [31:0] p);
    return {p[25:24], p[23:16]};
  endfunction

  // data = {b2, b3[3:0]}
  function automatic logic [11:0] payload_data(input logic [31:0] p);
    return {p[15:8], p[3:0]};
  endfunction

endpackage

// File: rtl/frame_parser.sv
// ---------------------------------------------------------------------------
// frame_parser
// Byte-level framing: finds START, unescapes payload bytes, counts them and
// judges the frame at STOP.
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_rx_data/valid   received byte and its one-cycle strobe
//   o_frame_good      STOP with exactly 4 bytes and a non-reserved cmd
//   o_frame_bad       any framing error (bad length/cmd, restart, abort)
//   o_payload         the four stored payload bytes {b0,b1,b2,b3}
// o_frame_good/o_frame_bad are combinational on the accepting byte so the
// executor can act on the very edge that samples STOP.
// ---------------------------------------------------------------------------
module frame_parser
  import loader_pkg::*;
#(
  parameter logic [7:0] START_BYTE = DEF_START_BYTE,
  parameter logic [7:0] STOP_BYTE  = DEF_STOP_BYTE,
  parameter logic [7:0] ESC_BYTE   = DEF_ESC_BYTE
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_frame_good,
  output logic        o_frame_bad,
  output logic [31:0] o_payload
);

  parser_state_e r_state;
  logic [2:0]    r_cnt;
  logic [31:0]   r_payload;

  logic       w_is_start;
  logic       w_is_stop;
  logic       w_is_esc;
  logic       w_body_ok;
  logic       w_store;
  logic [7:0] w_store_byte;
  logic       w_good;
  logic       w_bad;

  assign w_is_start = (i_rx_data == START_BYTE);
  assign w_is_stop  = (i_rx_data == STOP_BYTE);
  assign w_is_esc   = (i_rx_data == ESC_BYTE);
  assign w_body_ok  = (r_cnt == CNT_FULL) && (payload_cmd(r_payload) != RSVD);

  // Classify the incoming byte: store it, end the frame, or flag an error.
  always_comb begin
    w_store      = 1'b0;
    w_store_byte = i_rx_data;
    w_good       = 1'b0;
    w_bad        = 1'b0;
    if (i_rx_valid) begin
      case (r_state)
        P_IDLE: begin
          w_store = 1'b0;
        end
        P_BODY: begin
          if (w_is_start) begin
            w_bad = (r_cnt != 3'd0);
          end else if (w_is_esc) begin
            w_store = 1'b0;
          end else if (w_is_stop) begin
            w_good = w_body_ok;
            w_bad  = !w_body_ok;
          end else begin
            w_store = 1'b1;
          end
        end
        P_ESC: begin
          if (w_is_start || w_is_stop) begin
            w_bad = 1'b1;
          end else begin
            w_store      = 1'b1;
            w_store_byte = i_rx_data ^ ESC_XOR;
          end
        end
        default: begin
          w_store = 1'b0;
        end
      endcase
    end else begin
      w_store = 1'b0;
    end
  end

  // Parser state, saturating byte count and payload storage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= P_IDLE;
      r_cnt     <= 3'd0;
      r_payload <= 32'd0;
    end else begin
      if (i_rx_valid) begin
        case (r_state)
          P_IDLE: begin
            if (w_is_start) begin
              r_cnt   <= 3'd0;
              r_state <= P_BODY;
            end
          end
          P_BODY: begin
            if (w_is_start) begin
              r_cnt <= 3'd0;
            end else if (w_is_esc) begin
              r_state <= P_ESC;
            end else if (w_is_stop) begin
              r_state <= P_IDLE;
            end
          end
          P_ESC: begin
            if (w_is_start || w_is_stop) begin
              r_state <= P_IDLE;
            end else begin
              r_state <= P_BODY;
            end
          end
          default: r_state <= P_IDLE;
        endcase
      end
      // Only the first four bytes are kept; the count keeps going to 5 so an
      // over-long frame is still recognised at STOP.
      if (w_store) begin
        if (r_cnt < CNT_FULL) begin
          case (r_cnt[1:0])
            2'd0:    r_payload[31:24] <= w_store_byte;
            2'd1:    r_payload[23:16] <= w_store_byte;
            2'd2:    r_payload[15:8]  <= w_store_byte;
            default: r_payload[7:0]   <= w_store_byte;
          endcase
        end
        if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + 3'd1;
        end
      end
    end
  end

  assign o_frame_good = w_good;
  assign o_frame_bad  = w_bad;
  assign o_payload    = r_payload;

endmodule

// File: rtl/uart_mem_loader.sv
// ---------------------------------------------------------------------------
// uart_mem_loader
// Executes validated frames: 12-bit memory writes as three 10-bit bus beats,
// RUN/LOAD control of CPU reset and bus ownership, and one ACK/NAK byte per
// frame.
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_rx_data/valid   received byte stream
//   o_addr_data       bus beat (addr, data[5:0], data[11:6])
//   o_read_write      high on every bus beat
//   o_write_commit    high on the final beat
//   o_bus_own         1: loader owns the memory bus
//   o_cpu_rst         CPU reset, active-high
//   o_tx_data/o_tx_send  response byte and one-cycle send pulse
//   i_tx_busy         transmitter busy, holds the response
//   o_err_cnt         saturating error count
// ---------------------------------------------------------------------------
module uart_mem_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] START_BYTE = DEF_START_BYTE,
  parameter logic [7:0] STOP_BYTE  = DEF_STOP_BYTE,
  parameter logic [7:0] ESC_BYTE   = DEF_ESC_BYTE,
  parameter logic [7:0] ACK_BYTE   = DEF_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE   = DEF_NAK_BYTE
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [9:0] o_addr_data,
  output logic       o_read_write,
  output logic       o_write_commit,
  output logic       o_bus_own,
  output logic       o_cpu_rst,
  output logic [7:0] o_tx_data,
  output logic       o_tx_send,
  input  logic       i_tx_busy,
  output logic [7:0] o_err_cnt
);

  logic        w_frame_good;
  logic        w_frame_bad;
  logic [31:0] w_payload;
  logic        w_err_inc;

  exec_state_e r_xstate;
  logic [11:0] r_data;
  logic [7:0]  r_resp;
  logic [9:0]  r_addr_data;
  logic        r_read_write;
  logic        r_write_commit;
  logic        r_bus_own;
  logic        r_cpu_rst;
  logic [7:0]  r_tx_data;
  logic        r_tx_send;
  logic [7:0]  r_err_cnt;

  frame_parser #(
    .START_BYTE (START_BYTE),
    .STOP_BYTE  (STOP_BYTE),
    .ESC_BYTE   (ESC_BYTE)
  ) u_parser (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_frame_good (w_frame_good),
    .o_frame_bad  (w_frame_bad),
    .o_payload    (w_payload)
  );

  // Every rejected frame counts as one error: framing faults, a frame that
  // arrives while a response is still pending, and a WRITE without the bus.
  always_comb begin
    w_err_inc = 1'b0;
    if (w_frame_bad) begin
      w_err_inc = 1'b1;
    end else if (w_frame_good) begin
      if (r_xstate != X_IDLE) begin
        w_err_inc = 1'b1;
      end else if ((payload_cmd(w_payload) == WRITE) && !r_bus_own) begin
        w_err_inc = 1'b1;
      end else begin
        w_err_inc = 1'b0;
      end
    end else begin
      w_err_inc = 1'b0;
    end
  end

  // Executor FSM with registered bus, control and response outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_xstate       <= X_IDLE;
      r_data         <= 12'd0;
      r_resp         <= 8'd0;
      r_addr_data    <= 10'd0;
      r_read_write   <= 1'b0;
      r_write_commit <= 1'b0;
      r_bus_own      <= 1'b1;
      r_cpu_rst      <= 1'b1;
      r_tx_data      <= 8'd0;
      r_tx_send      <= 1'b0;
      r_err_cnt      <= 8'd0;
    end else begin
      r_addr_data    <= 10'd0;
      r_read_write   <= 1'b0;
      r_write_commit <= 1'b0;
      r_tx_send      <= 1'b0;

      case (r_xstate)
        X_IDLE: begin
          if (w_frame_good) begin
            r_data <= payload_data(w_payload);
            case (payload_cmd(w_payload))
              WRITE: begin
                if (r_bus_own) begin
                  // Address beat goes out on the cycle right after STOP.
                  r_resp       <= ACK_BYTE;
                  r_addr_data  <= payload_addr(w_payload);
                  r_read_write <= 1'b1;
                  r_xstate     <= X_ADDR;
                end else begin
                  r_resp   <= NAK_BYTE;
                  r_xstate <= X_RESP;
                end
              end
              RUN: begin
                r_cpu_rst <= 1'b0;
                r_bus_own <= 1'b0;
                r_resp    <= ACK_BYTE;
                r_xstate  <= X_RESP;
              end
              LOAD: begin
                r_cpu_rst <= 1'b1;
                r_bus_own <= 1'b1;
                r_resp    <= ACK_BYTE;
                r_xstate  <= X_RESP;
              end
              default: begin
                r_resp   <= NAK_BYTE;
                r_xstate <= X_RESP;
              end
            endcase
          end else if (w_frame_bad) begin
            r_resp   <= NAK_BYTE;
            r_xstate <= X_RESP;
          end else begin
            r_xstate <= X_IDLE;
          end
        end
        X_ADDR: begin
          r_addr_data  <= {4'b0000, r_data[5:0]};
          r_read_write <= 1'b1;
          r_xstate     <= X_DLO;
        end
        X_DLO: begin
          r_addr_data    <= {4'b0000, r_data[11:6]};
          r_read_write   <= 1'b1;
          r_write_commit <= 1'b1;
          r_xstate       <= X_DHI;
        end
        X_DHI: begin
          // Send straight out of the commit beat when the transmitter is free.
          r_xstate <= X_RESP;
          if (!i_tx_busy) begin
            r_tx_send <= 1'b1;
            r_tx_data <= r_resp;
          end
        end
        X_RESP: begin
          if (r_tx_send) begin
            r_xstate <= X_IDLE;
          end else if (!i_tx_busy) begin
            r_tx_send <= 1'b1;
            r_tx_data <= r_resp;
          end
        end
        default: r_xstate <= X_IDLE;
      endcase

      if (w_err_inc && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign o_addr_data    = r_addr_data;
  assign o_read_write   = r_read_write;
  assign o_write_commit = r_write_commit;
  assign o_bus_own      = r_bus_own;
  assign o_cpu_rst      = r_cpu_rst;
  assign o_tx_data      = r_tx_data;
  assign o_tx_send      = r_tx_send;
  assign o_err_cnt      = r_err_cnt;

endmodule
